// File: rtl/aes_mixcol_iter.sv
// Iterative AES MixColumns / InvMixColumns over a 128-bit state.
// COLS_PER_CYCLE column units rewrite the working register in place, lowest column first.
module aes_mixcol_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inverse,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("aes_mixcol_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // sender holds its data stable while valid is high and ready is low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic         mode_q;
    logic [1:0]   cnt_q;
    logic         last_step;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant: sum of the shifted xtime terms it selects.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ a;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [3:0]  k [4];
        logic [31:0] res;
        logic [7:0]  acc;
        logic [1:0]  idx;
        if (inv) begin
            k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9;
        end else begin
            k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1;
        end
        res = 32'h0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                idx = 2'(j - r);
                acc = acc ^ gmul(c[8*j +: 8], k[idx]);
            end
            res[8*r +: 8] = acc;
        end
        return res;
    endfunction

    assign last_step = (cnt_q == LAST_CNT);

    always_comb begin
        logic [1:0] col;
        work_d = work_q;
        col    = cnt_q;
        for (int u = 0; u < COLS_PER_CYCLE; u++) begin
            col = cnt_q + 2'(u);
            work_d[32*col +: 32] = mix_col(work_q[32*col +: 32], mode_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        dbg_state = state_q;
    end

    // The counter stops at its final value so it never wraps inside a job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            mode_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    work_q <= state_in;
                    mode_q <= inverse;
                    cnt_q  <= 2'd0;
                end
                RUN: begin
                    work_q <= work_d;
                    if (!last_step) cnt_q <= cnt_q + CNT_STEP;
                end
                default: ;
            endcase
        end
    end

    assign state_out = work_q;

endmodule

// File: tb/tb_aes_mixcol_iter.sv
// Directed bench for aes_mixcol_iter: three instances (1, 2, 4 columns per cycle)
// share the inputs and are checked against hand-computed MixColumns results.
module tb_aes_mixcol_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         inverse;
    logic         out_ready;
    logic [127:0] state_in;

    logic [127:0] so [3];
    logic         ov [3];
    logic         ir [3];
    logic         bz [3];
    logic [1:0]   ds [3];

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] VEC_A     = {4{32'h455313DB}};
    localparam logic [127:0] VEC_A_FWD = {4{32'hBCA14D8E}};
    localparam logic [127:0] VEC_MIX     = {32'hC6C6C6C6, 32'h01010101, 32'h5C220AF2, 32'h455313DB};
    localparam logic [127:0] VEC_MIX_FWD = {32'hC6C6C6C6, 32'h01010101, 32'h9D58DC9F, 32'hBCA14D8E};
    localparam logic [127:0] VEC_FIPS     = 128'he598271ef11141b8ae52b4e0305dbfd4;
    localparam logic [127:0] VEC_FIPS_FWD = 128'h4c2606287ad3f8489a19cbe0e5816604;
    localparam logic [127:0] VEC_ONES = {16{8'h01}};
    localparam logic [127:0] VEC_C6   = {16{8'hC6}};
    localparam logic [127:0] VEC_ZERO = 128'h0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            aes_mixcol_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (ir[g]),
                .inverse   (inverse),
                .state_in  (state_in),
                .out_valid (ov[g]),
                .out_ready (out_ready),
                .state_out (so[g]),
                .busy      (bz[g]),
                .dbg_state (ds[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input int g, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[cpc%0d]: got %h, expected %h", tag, 1 << g, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        for (int g = 0; g < 3; g++) begin
            check("rst_out_valid", g, ov[g], 1'b0);
            check("rst_busy", g, bz[g], 1'b0);
            check("rst_in_ready", g, ir[g], 1'b1);
            check("rst_state_out", g, so[g], 128'h0);
            check("rst_dbg_state", g, ds[g], 2'd0);
        end
    endtask

    task automatic disturb_inputs();
        in_valid = 1'b1;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        inverse  = ~inverse;
    endtask

    // Caller is positioned at a negedge with every instance idle.
    task automatic run_job(input logic [127:0] din, input logic inv, input logic [127:0] exp,
                           input bit disturb, input int hold);
        logic [127:0] e;
        exp_q.push_back(exp);
        in_valid = 1'b1;
        state_in = din;
        inverse  = inv;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("accept_busy", g, bz[g], 1'b1);
            check("accept_in_ready", g, ir[g], 1'b0);
        end
        if (disturb) disturb_inputs();
        else in_valid = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++)
                check("latency_out_valid", g, ov[g], 1'(cyc >= (4 >> g)));
            if (disturb) disturb_inputs();
        end
        e = exp_q.pop_front();
        for (int g = 0; g < 3; g++) check("result", g, so[g], e);
        for (int h = 0; h < hold; h++) begin
            disturb_inputs();
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                check("hold_out_valid", g, ov[g], 1'b1);
                check("hold_in_ready", g, ir[g], 1'b0);
                check("hold_state_out", g, so[g], e);
            end
        end
        // Release with a job already offered: it must not be taken on the release edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        state_in  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("release_in_ready", g, ir[g], 1'b1);
            check("release_out_valid", g, ov[g], 1'b0);
            check("release_busy", g, bz[g], 1'b0);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        inverse   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        inverse   = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(VEC_A, 1'b0, VEC_A_FWD, 1'b0, 0);
        run_job(VEC_A_FWD, 1'b1, VEC_A, 1'b1, 5);
        run_job(VEC_MIX, 1'b0, VEC_MIX_FWD, 1'b1, 0);
        run_job(VEC_MIX_FWD, 1'b1, VEC_MIX, 1'b0, 2);
        run_job(VEC_FIPS, 1'b0, VEC_FIPS_FWD, 1'b0, 0);
        run_job(VEC_FIPS_FWD, 1'b1, VEC_FIPS, 1'b1, 1);
        run_job(VEC_ONES, 1'b0, VEC_ONES, 1'b0, 0);
        run_job(VEC_ONES, 1'b1, VEC_ONES, 1'b0, 0);
        run_job(VEC_C6, 1'b0, VEC_C6, 1'b0, 0);
        run_job(VEC_C6, 1'b1, VEC_C6, 1'b0, 0);
        run_job(VEC_ZERO, 1'b0, VEC_ZERO, 1'b0, 0);
        run_job(VEC_ZERO, 1'b1, VEC_ZERO, 1'b0, 0);

        // Reset one cycle into a job: everything returns to idle, no result appears.
        in_valid = 1'b1;
        state_in = VEC_FIPS;
        inverse  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) check("rst_hold_out_valid", g, ov[g], 1'b0);
        end
        rst_n = 1'b1;
        run_job(VEC_FIPS, 1'b0, VEC_FIPS_FWD, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_mixcol_iter.md
AES_MIXCOL_ITER -- requirements
Module: aes_mixcol_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, giving columns transformed per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  state_in/inverse carry a valid job.
REQ-005 SHALL have port in_ready  output  1  block can accept a job.
REQ-006 SHALL have port inverse  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with the job.
REQ-007 SHALL have port state_in  input  128  input state; byte i = state_in[8i+7:8i]; column c = bytes 4c..4c+3, byte 4c = row 0.
REQ-008 SHALL have port out_valid  output  1  state_out holds a completed result.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port state_out  output  128  result, same byte/column mapping as state_in.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 IDLE: on in_valid&&in_ready at an edge, SHALL latch state_in into working register, latch inverse into mode register, clear column counter to 0, go to RUN.
REQ-014 RUN: each cycle SHALL replace COLS_PER_CYCLE columns, starting at counter value, with their transform, then add COLS_PER_CYCLE to counter.
REQ-015 Columns SHALL be processed in ascending order 0..3; untouched columns hold their values.
REQ-016 After the cycle that processes column 3, SHALL go to DONE; RUN lasts exactly 4/COLS_PER_CYCLE cycles.
REQ-017 Latency: job accepted at edge k SHALL give out_valid=1 after edge k+4/COLS_PER_CYCLE.
REQ-018 DONE: state_out SHALL hold stable until out_valid&&out_ready at an edge, then go to IDLE.
REQ-019 state_out SHALL be driven directly from the working register in all states (not gated by out_valid).
REQ-020 Forward column transform SHALL multiply by circulant matrix rows {02,03,01,01} over GF(2^8) with reduction polynomial 0x11B.
REQ-021 Inverse column transform SHALL multiply by circulant matrix rows {0E,0B,0D,09} over the same field.
REQ-022 in_valid, inverse and state_in SHALL be ignored outside IDLE; changes to them during RUN/DONE SHALL not alter the job.
REQ-023 Counter SHALL be 2 bits and SHALL not wrap within a job; counter value is don't-care in IDLE/DONE.
REQ-024 No new job SHALL be accepted in the cycle a result is released; in_ready rises the cycle after the DONE->IDLE edge.
REQ-025 Datapath SHALL be purely combinational between working register and its next value; no multiplier shared across cycles beyond COLS_PER_CYCLE column units.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, out_valid=0, busy=0, in_ready=1, working register=0 (state_out=0), mode=0, counter=0.
REQ-027 Reset asserted during RUN or DONE SHALL abandon the job with no result produced.
REQ-028 First job after rst_n deassertion SHALL be acceptable at the first rising edge with rst_n high.

Verification
REQ-029 Forward vector: all four columns = 32'h455313DB (bytes DB,13,53,45), inverse=0 -> every column 32'hBCA14D8E (8E,4D,A1,BC); out_valid after 4 edges (COLS_PER_CYCLE=1), 2 (=2), 1 (=4).
REQ-030 Round trip: result of REQ-029 fed back with inverse=1 -> every column 32'h455313DB; also column F2,0A,22,5C forward -> 9F,DC,58,9D.
REQ-031 Fixed points: all bytes 01 -> unchanged; all bytes C6 -> unchanged; all zero -> zero; both modes.
REQ-032 Backpressure: out_ready held low 5 cycles in DONE -> state_out and out_valid stable, in_ready=0, toggled in_valid/state_in/inverse ignored; out_ready high -> IDLE next edge, in_ready=1.
REQ-033 Mid-job disturbance: flip inverse and state_in during RUN -> result identical to undisturbed job.
REQ-034 Reset mid-RUN (after 1 cycle, COLS_PER_CYCLE=1) -> outputs immediately at REQ-026 values; no out_valid; following job completes correctly.
